// File: rtl/servo_pkg.sv
// Shared types and parameter derivations for the servo PDM decoder.
package servo_pkg;

    typedef logic [7:0] duty_t;

    typedef enum logic {IDLE, RUN} state_t;

    localparam int HCNT_W = 13;

    function automatic int frame_samples(input int pdm_hz, input int cyc_hz);
        return pdm_hz / cyc_hz;
    endfunction

    function automatic int sample_div(input int clk_hz, input int pdm_hz);
        return clk_hz / pdm_hz;
    endfunction

    // ceil(2^24 / fs): scales a 0..fs high count to 0..256 after >>16
    function automatic int scale_mul(input int fs);
        return int'((64'd16777216 + 64'(fs) - 64'd1) / 64'(fs));
    endfunction

endpackage

// File: rtl/servo_line_sync.sv
// 2-FF synchronizer for the asynchronous PDM line plus registered edge detect.
module servo_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic pdm,
    output logic line,
    output logic rise,
    output logic fall,
    output logic any
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
            any  <= 1'b0;
        end else begin
            s1   <= pdm;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
            fall <= ~s2 & s3;
            any  <= s2 ^ s3;
        end
    end

    assign line = s2;

endmodule

// File: rtl/servo_pdm_decoder.sv
// Recovers an 8-bit duty value from a servo PDM/PWM stream, one strobe per frame.
// Optional SERVO_DEC_WATCHDOG_EN adds the edge-based signal_lost watchdog.
module servo_pdm_decoder
    import servo_pkg::*;
#(
    parameter int clk_hz      = 25000000,
    parameter int cyc_hz      = 50,
    parameter int pdm_hz      = 312500,
    parameter int lost_frames = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  pdm,
    output duty_t duty,
    output logic  duty_valid,
    output logic  signal_lost
);

    localparam int FRAME_SAMPLES = frame_samples(pdm_hz, cyc_hz);
    localparam int SAMPLE_DIV    = sample_div(clk_hz, pdm_hz);
    localparam int SCALE_MUL     = scale_mul(FRAME_SAMPLES);
    localparam int DIV_W         = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int MUL_W         = $clog2(SCALE_MUL + 1);
    localparam int PROD_W        = HCNT_W + MUL_W;

    logic line, line_rise_unused, line_fall_unused, line_any;

    servo_line_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .pdm  (pdm),
        .line (line),
        .rise (line_rise_unused),
        .fall (line_fall_unused),
        .any  (line_any)
    );

    state_t              state, state_n;
    logic                run, tick, frame_end, lost_n;
    logic [DIV_W-1:0]    div;
    logic [HCNT_W-1:0]   frm, high_cnt, high_sum;
    logic [PROD_W-1:0]   prod, scaled;
    duty_t               duty_calc;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        run       = 1'b0;
        tick      = 1'b0;
        frame_end = 1'b0;
        case (state)
            IDLE: if (en) state_n = RUN;
            RUN: begin
                if (!en) state_n = IDLE;
                else     run = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        tick      = run && (div == DIV_W'(SAMPLE_DIV - 1));
        frame_end = tick && (frm == HCNT_W'(FRAME_SAMPLES - 1));
    end

    // Final sample of the frame is folded in combinationally so the strobe lands one cycle later
    assign high_sum  = high_cnt + HCNT_W'(line);
    assign prod      = PROD_W'(high_sum) * PROD_W'(SCALE_MUL);
    assign scaled    = prod >> 16;
    assign duty_calc = (scaled > PROD_W'(255)) ? 8'hFF : scaled[7:0];

    // Leaving RUN (or not yet in it) discards any partial frame
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            div      <= '0;
            frm      <= '0;
            high_cnt <= '0;
        end else begin
            div <= tick ? '0 : div + DIV_W'(1);
            if (tick) begin
                if (frame_end) begin
                    frm      <= '0;
                    high_cnt <= '0;
                end else begin
                    frm      <= frm + HCNT_W'(1);
                    high_cnt <= high_sum;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty       <= '0;
            duty_valid <= 1'b0;
        end else begin
            duty_valid <= frame_end;
            if (frame_end) duty <= lost_n ? 8'h00 : duty_calc;
        end
    end

`ifdef SERVO_DEC_WATCHDOG_EN
    localparam int MISS_W = $clog2(lost_frames + 1);

    logic [MISS_W-1:0] miss, miss_n;
    logic              frame_edge, frame_edge_n;

    // Any edge clears the miss count at once; a frame with no edge at all bumps it
    always_comb begin
        frame_edge_n = frame_edge | line_any;
        miss_n       = line_any ? '0 : miss;
        if (frame_end && !frame_edge_n && (miss != MISS_W'(lost_frames)))
            miss_n = miss + MISS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            miss       <= '0;
            frame_edge <= 1'b0;
        end else begin
            miss       <= miss_n;
            frame_edge <= frame_end ? 1'b0 : frame_edge_n;
        end
    end

    assign lost_n      = (miss_n >= MISS_W'(lost_frames));
    assign signal_lost = (miss >= MISS_W'(lost_frames));
`else
    logic unused_edge;
    assign unused_edge = line_any;
    assign lost_n      = 1'b0;
    assign signal_lost = 1'b0;
`endif

endmodule
